lgdst_txts_gen: RTL and testbench

TX-side counterpart of the RX TS-to-SPI glue. Accepts transport-stream bytes written by the Atmel host over a SPI slave port, buffers them in a byte FIFO, and re-serialises complete 188-byte packets onto a serial TS interface (ts_clk/ts_d0/ts_valid/ts_sync) toward the modulator. Status is returned to the host on MISO.

---
 rtl/lgdst_txts_gen.sv | 158 +++++++++++++++
 tb/tb_lgdst_txts_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lgdst_txts_gen.sv
// lgdst_txts_gen: SPI-slave byte sink feeding a FIFO that is replayed as serial TS packets.
module lgdst_txts_gen #(
    parameter int         CLK_DIV   = 4,
    parameter int         FIFO_AW   = 9,
    parameter int         PKT_LEN   = 188,
    parameter logic [7:0] SYNC_BYTE = 8'h47,
    parameter int         GAP_BITS  = 16
) (
    input  logic clk,
    input  logic resync_n,
    input  logic spi_spck,
    input  logic spi_npcs,
    input  logic spi_mosi,
    output logic spi_miso,
    input  logic clr_err,
    output logic ts_clk,
    output logic ts_d0,
    output logic ts_valid,
    output logic ts_sync,
    output logic fifo_full,
    output logic ovf_err,
    output logic sync_err
);
    localparam int NBITS = PKT_LEN * 8;
    localparam int BW    = $clog2(NBITS);
    localparam int GW    = $clog2(GAP_BITS + 1);
    localparam int DW    = $clog2(CLK_DIV);
    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW + 1)'(2 ** FIFO_AW);
    localparam logic [FIFO_AW:0] PKT_L = (FIFO_AW + 1)'(PKT_LEN);
    localparam logic [BW-1:0]    LAST  = BW'(NBITS - 1);
    localparam logic [GW-1:0]    GAP_L = GW'(GAP_BITS);
    localparam logic [DW-1:0]    DIV_L = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    logic [2:0]         spck_s;
    logic [1:0]         npcs_s, mosi_s;
    logic [2:0]         spi_cnt;
    logic [6:0]         spi_sr;
    logic [7:0]         miso_sr;
    logic [7:0]         mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [FIFO_AW:0]   level;
    logic [DW-1:0]      div;
    state_t             state, nstate;
    logic [BW-1:0]      bcnt;
    logic [7:0]         tx_sr, head;
    logic [GW-1:0]      gap;
    logic               npcs, spck_rise, spck_fall, byte_done, push, pop, drop, fe;

    assign npcs      = npcs_s[1];
    assign spck_rise = spck_s[1] & ~spck_s[2];
    assign spck_fall = ~spck_s[1] & spck_s[2];
    assign byte_done = spck_rise & ~npcs & (&spi_cnt);
    assign push      = byte_done & ~fifo_full;
    assign fifo_full = level == DEPTH;
    assign head      = mem[rptr];
    assign spi_miso  = miso_sr[7];
    assign fe        = (div == DIV_L) & ts_clk;
    assign ts_valid  = state == SEND;
    assign ts_sync   = ts_valid & (bcnt[BW-1:3] == '0);
    assign ts_d0     = ts_valid & tx_sr[7];

    always_ff @(posedge clk or negedge resync_n) begin
        if (!resync_n) begin
            spck_s  <= '0;
            npcs_s  <= '1;
            mosi_s  <= '0;
            spi_cnt <= '0;
            spi_sr  <= '0;
            miso_sr <= '0;
        end else begin
            spck_s <= {spck_s[1:0], spi_spck};
            npcs_s <= {npcs_s[0], spi_npcs};
            mosi_s <= {mosi_s[0], spi_mosi};
            if (npcs) begin
                spi_cnt <= '0;
                miso_sr <= {fifo_full, level == '0, ovf_err, sync_err, level[FIFO_AW-1:FIFO_AW-4]};
            end else begin
                if (spck_rise) begin
                    spi_cnt <= spi_cnt + 1'b1;
                    spi_sr  <= {spi_sr[5:0], mosi_s[1]};
                end
                if (spck_fall) miso_sr <= {miso_sr[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {spi_sr, mosi_s[1]};
    end

    always_ff @(posedge clk or negedge resync_n) begin
        if (!resync_n) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            ovf_err  <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            level    <= level + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
            ovf_err  <= (byte_done & fifo_full) | (ovf_err & ~clr_err);
            sync_err <= drop | (sync_err & ~clr_err);
        end
    end

    always_ff @(posedge clk or negedge resync_n) begin
        if (!resync_n) begin
            div    <= '0;
            ts_clk <= 1'b0;
        end else begin
            div <= (div == DIV_L) ? '0 : div + 1'b1;
            if (div == DIV_L) ts_clk <= ~ts_clk;
        end
    end

    always_ff @(posedge clk or negedge resync_n) begin
        if (!resync_n) state <= IDLE;
        else state <= nstate;
    end

    // The head byte is consumed on the same ts_clk fall that starts its first bit.
    always_comb begin
        nstate = state;
        pop    = 1'b0;
        drop   = 1'b0;
        if (fe) begin
            case (state)
                IDLE: if (level >= PKT_L && gap == GAP_L) begin
                    pop    = 1'b1;
                    drop   = head != SYNC_BYTE;
                    nstate = drop ? IDLE : SEND;
                end
                SEND: begin
                    pop    = (&bcnt[2:0]) && bcnt != LAST;
                    nstate = (bcnt == LAST) ? GAP : SEND;
                end
                GAP:     nstate = (gap == GAP_L - 1'b1) ? IDLE : GAP;
                default: nstate = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resync_n) begin
        if (!resync_n) begin
            bcnt  <= '0;
            tx_sr <= '0;
            gap   <= '0;
        end else if (fe) begin
            bcnt  <= (state == SEND) ? bcnt + 1'b1 : '0;
            tx_sr <= pop ? head : {tx_sr[6:0], 1'b0};
            gap   <= (state == SEND && nstate == GAP) ? '0 :
                     (state != SEND && gap != GAP_L) ? gap + 1'b1 : gap;
        end
    end
endmodule

// File: tb/tb_lgdst_txts_gen.sv
// tb_lgdst_txts_gen: SPI-driven bench comparing serial TS packets with a byte-queue model.
module tb_lgdst_txts_gen;
    localparam int         CLK_DIV  = 2;
    localparam int         FIFO_AW  = 5;
    localparam int         PKT_LEN  = 16;
    localparam int         GAP_BITS = 1200;
    localparam logic [7:0] SYNC     = 8'h47;
    localparam int         HP       = 50;

    logic clk = 1'b0, resync_n = 1'b0, spi_spck = 1'b0, spi_npcs = 1'b1, spi_mosi = 1'b0, clr_err = 1'b0;
    logic spi_miso, ts_clk, ts_d0, ts_valid, ts_sync, fifo_full, ovf_err, sync_err;

    int n_checks = 0, n_errors = 0;
    int pkt_count = 0, n_starts = 0, nbits = 0, gap_cnt = 0, sync_bad = 0, idle_bad = 0;
    logic in_pkt = 1'b0, prev_tsclk = 1'b0;
    logic [7:0] acc = '0;
    byte unsigned mq[$];
    byte unsigned rx_q[$];

    always #5 clk = ~clk;

    lgdst_txts_gen #(
        .CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW), .PKT_LEN(PKT_LEN), .SYNC_BYTE(SYNC), .GAP_BITS(GAP_BITS)
    ) dut (
        .clk(clk), .resync_n(resync_n), .spi_spck(spi_spck), .spi_npcs(spi_npcs), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .clr_err(clr_err), .ts_clk(ts_clk), .ts_d0(ts_d0), .ts_valid(ts_valid),
        .ts_sync(ts_sync), .fifo_full(fifo_full), .ovf_err(ovf_err), .sync_err(sync_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: junk ahead of a sync byte is discarded, then one packet's worth leaves in order.
    task automatic end_packet;
        logic [8:0] e, g;
        check("pkt_bits", nbits, PKT_LEN * 8);
        check("pkt_sync", sync_bad, 0);
        while (mq.size() > 0 && mq[0] != SYNC) void'(mq.pop_front());
        for (int i = 0; i < PKT_LEN; i++) begin
            e = 9'h1ff;
            g = 9'h1fe;
            if (mq.size() > 0) e = {1'b0, mq.pop_front()};
            if (i < rx_q.size()) g = {1'b0, rx_q[i]};
            check($sformatf("pkt%0d_byte%0d", pkt_count, i), g, e);
        end
        pkt_count++;
    endtask

    always @(negedge clk) begin
        if (!resync_n) begin
            in_pkt = 1'b0;
            nbits = 0;
            gap_cnt = 0;
            prev_tsclk = 1'b0;
            rx_q.delete();
        end else begin
            if (ts_clk && !prev_tsclk) begin
                if (ts_valid) begin
                    if (!in_pkt) begin
                        check("gap", gap_cnt >= GAP_BITS, 1);
                        in_pkt = 1'b1;
                        nbits = 0;
                        sync_bad = 0;
                        rx_q.delete();
                        n_starts++;
                    end
                    if (ts_sync !== (nbits < 8)) sync_bad++;
                    acc = {acc[6:0], ts_d0};
                    nbits++;
                    if (nbits % 8 == 0) rx_q.push_back(acc);
                end else begin
                    if (ts_sync || ts_d0) idle_bad++;
                    if (in_pkt) begin
                        end_packet();
                        in_pkt = 1'b0;
                        gap_cnt = 1;
                    end else gap_cnt++;
                end
            end
            prev_tsclk = ts_clk;
        end
    end

    task automatic spi_xfer(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        spi_npcs = 1'b0;
        for (int i = 0; i < n; i++) begin
            spi_mosi = tx[7-i];
            #HP;
            rx[7-i] = spi_miso;
            spi_spck = 1'b1;
            #HP;
            spi_spck = 1'b0;
        end
        #HP;
        if (n < 8) rx[7-n] = spi_miso;
        spi_npcs = 1'b1;
        spi_mosi = 1'b0;
        #(3 * HP);
    endtask

    task automatic spi_write(input logic [7:0] b);
        logic [7:0] d;
        spi_xfer(b, 8, d);
        mq.push_back(b);
    endtask

    task automatic read_status(output logic [7:0] s);
        spi_xfer(8'h00, 7, s);
    endtask

    task automatic send_pkt(input bit rnd, input int nb);
        spi_write(SYNC);
        for (int i = 1; i < nb; i++) spi_write(rnd ? 8'($urandom) : 8'(i - 1));
    endtask

    task automatic wait_pkts(input int n);
        for (int i = 0; i < 20000 && pkt_count < n; i++) @(negedge clk);
        check("pkt_done", pkt_count >= n, 1);
    endtask

    task automatic pulse_clr;
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        resync_n = 1'b0;
        mq.delete();
        repeat (3) @(negedge clk);
        resync_n = 1'b1;
    endtask

    initial begin
        logic [7:0] st;
        int junk;
        logic [7:0] jb;
        repeat (3) @(negedge clk);
        check("rst_outs", {ts_clk, ts_d0, ts_valid, ts_sync, spi_miso, fifo_full, ovf_err, sync_err}, 0);
        resync_n = 1'b1;
        read_status(st);
        check("status_empty", st, 8'h40);
        spi_xfer(8'hFF, 5, st);
        read_status(st);
        check("partial_no_push", st, 8'h40);

        send_pkt(0, PKT_LEN);
        wait_pkts(1);

        send_pkt(1, PKT_LEN - 1);
        repeat (6000) @(negedge clk);
        check("short_no_start", n_starts, 1);
        spi_write(8'($urandom));
        wait_pkts(2);

        spi_write(8'h12);
        send_pkt(1, PKT_LEN);
        wait_pkts(3);
        check("sync_err_set", sync_err, 1);
        pulse_clr;
        check("sync_err_clr", sync_err, 0);
        check("ovf_clean", ovf_err, 0);

        do_reset;
        send_pkt(1, PKT_LEN);
        send_pkt(1, PKT_LEN);
        read_status(st);
        check("status_full", st, 8'h80);
        check("full_flag", fifo_full, 1);
        spi_xfer(8'hAB, 8, st);
        check("ovf_set", ovf_err, 1);
        read_status(st);
        check("status_ovf", st, 8'hA0);
        pulse_clr;
        check("ovf_clr", ovf_err, 0);
        wait_pkts(5);
        read_status(st);
        check("status_drained", st, 8'h40);

        send_pkt(1, PKT_LEN);
        repeat (5) spi_write(8'($urandom));
        for (int i = 0; i < 20000 && !(in_pkt && nbits >= 60); i++) @(negedge clk);
        check("reached_bit60", in_pkt && nbits >= 60, 1);
        #2;
        resync_n = 1'b0;
        #1;
        check("rst_async", {ts_clk, ts_d0, ts_valid, ts_sync}, 0);
        mq.delete();
        repeat (2) @(negedge clk);
        resync_n = 1'b1;
        read_status(st);
        check("status_after_rst", st, 8'h40);

        for (int r = 0; r < 2; r++) begin
            junk = int'($urandom_range(0, 2));
            for (int j = 0; j < junk; j++) begin
                jb = 8'($urandom_range(0, 255));
                if (jb == SYNC) jb = 8'h00;
                spi_write(jb);
            end
            send_pkt(1, PKT_LEN);
            wait_pkts(6 + r);
            check("rand_sync_err", sync_err, junk > 0);
            pulse_clr;
        end
        check("idle_low", idle_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
